// File: rtl/pixel_pack_pkg.sv
// pixel_pack_pkg: shared constants, FIFO entry and write-FSM types for pixel_pack_writer.
// Constants below describe the default build; modules derive their own through pp_clog2.
package pixel_pack_pkg;
   function automatic int pp_clog2(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_BUS_WIDTH   = 32;
   localparam int LANES           = DEF_BUS_WIDTH / DEF_DATA_WIDTH;
   localparam int LANE_CNT_W      = pp_clog2(LANES);
   localparam int FRAME_PIX       = 4 * 4;
   localparam int PIX_CNT_W       = pp_clog2(FRAME_PIX);
   localparam int WORDS_PER_FRAME = (FRAME_PIX + LANES - 1) / LANES;
   typedef struct packed {
      logic                     last;
      logic [LANES-1:0]         be;
      logic [DEF_BUS_WIDTH-1:0] wdata;
   } fifo_entry_t;
   typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} wr_state_e;
endpackage

// File: rtl/pixel_pack_writer_fifo.sv
// pp_sync_fifo: single-clock FIFO with full/empty flags; a push while full is
// accepted only when a pop happens in the same cycle.
module pp_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;
   always_comb begin
      pop_ok  = i_pop && (cnt_q != '0);
      push_ok = i_push && ((cnt_q != (AW+1)'(DEPTH)) || pop_ok);
      wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
      rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
      cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_q] <= i_din;
   end
   assign o_dout  = mem[rd_q];
   assign o_full  = cnt_q == (AW+1)'(DEPTH);
   assign o_empty = cnt_q == '0;
   assign o_count = cnt_q;
endmodule

// File: rtl/pixel_pack_writer.sv
// pixel_pack_writer: packs a pixel stream into bus words, buffers them and writes
// them to a frame buffer over req/ack. PACK_BIG_ENDIAN_EN puts the first pixel in the top lane.
module pixel_pack_writer
   import pixel_pack_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int WIDTH_IMAG  = 4,
   parameter int HEIGHT_IMAG = 4,
   parameter int BUS_WIDTH   = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_wr,
   input  logic [DATA_WIDTH-1:0]             i_data,
   output logic                              o_mem_req,
   output logic [ADDR_WIDTH-1:0]             o_mem_addr,
   output logic [BUS_WIDTH-1:0]              o_mem_wdata,
   output logic [BUS_WIDTH/DATA_WIDTH-1:0]   o_mem_be,
   input  logic                              i_mem_ack,
   output logic                              o_frame_done,
   output logic                              o_overflow,
   input  logic                              i_clr
);
   localparam int NL   = BUS_WIDTH / DATA_WIDTH;
   localparam int LCW  = pp_clog2(NL);
   localparam int NPIX = WIDTH_IMAG * HEIGHT_IMAG;
   localparam int PCW  = pp_clog2(NPIX);
   localparam int EW   = 1 + NL + BUS_WIDTH;
   localparam logic [LCW-1:0] LAST_LANE = LCW'(NL - 1);
   localparam logic [PCW-1:0] LAST_PIX  = PCW'(NPIX - 1);
   typedef struct packed {
      logic                 last;
      logic [NL-1:0]        be;
      logic [BUS_WIDTH-1:0] wdata;
   } entry_t;
   logic [BUS_WIDTH-1:0]  pack_q, pack_d, word_ins;
   logic [NL-1:0]         be_q, be_d, be_ins;
   logic [LCW-1:0]        lane_cnt_q, lane_cnt_d, lane_idx;
   logic [PCW-1:0]        pix_cnt_q, pix_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   wr_state_e             state_q, state_d;
   logic                  frame_done_q, frame_done_d, overflow_q, overflow_d;
   logic                  last_pix, push, pop, drop, empty_next;
   logic                  fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
   entry_t                push_entry, head;
   logic [EW-1:0]         head_raw;
`ifdef PACK_BIG_ENDIAN_EN
   assign lane_idx = LAST_LANE - lane_cnt_q;
`else
   assign lane_idx = lane_cnt_q;
`endif
   always_comb begin
      word_ins = pack_q;
      be_ins   = be_q;
      for (int k = 0; k < NL; k++) begin
         if (LCW'(k) == lane_idx) begin
            word_ins[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
            be_ins[k] = 1'b1;
         end
      end
      last_pix   = pix_cnt_q == LAST_PIX;
      push       = i_wr && (lane_cnt_q == LAST_LANE || last_pix);
      pack_d     = push ? '0 : (i_wr ? word_ins : pack_q);
      be_d       = push ? '0 : (i_wr ? be_ins : be_q);
      lane_cnt_d = push ? '0 : (i_wr ? lane_cnt_q + 1'b1 : lane_cnt_q);
      pix_cnt_d  = i_wr ? (last_pix ? '0 : pix_cnt_q + 1'b1) : pix_cnt_q;
      push_entry = '{last: last_pix, be: be_ins, wdata: word_ins};
   end
   pp_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (push),
      .i_din   (push_entry),
      .i_pop   (pop),
      .o_dout  (head_raw),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_cnt)
   );
   assign head = entry_t'(head_raw);
   // The head slot only changes on a pop, so the presented word is stable while stalled.
   always_comb begin
      pop          = (state_q == REQ) && i_mem_ack;
      drop         = push && fifo_full && !pop;
      empty_next   = pop && (fifo_cnt == 1) && !push;
      state_d      = (state_q == IDLE) ? (fifo_empty ? IDLE : REQ) : (empty_next ? IDLE : REQ);
      addr_d       = pop ? (head.last ? BASE_ADDR : addr_q + 1'b1) : addr_q;
      frame_done_d = pop && head.last;
      overflow_d   = (overflow_q && !i_clr) || drop;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pack_q       <= '0;
         be_q         <= '0;
         lane_cnt_q   <= '0;
         pix_cnt_q    <= '0;
         addr_q       <= BASE_ADDR;
         state_q      <= IDLE;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         pack_q       <= pack_d;
         be_q         <= be_d;
         lane_cnt_q   <= lane_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         addr_q       <= addr_d;
         state_q      <= state_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end
   assign o_mem_req    = state_q == REQ;
   assign o_mem_addr   = addr_q;
   assign o_mem_wdata  = o_mem_req ? head.wdata : '0;
   assign o_mem_be     = o_mem_req ? head.be : '0;
   assign o_frame_done = frame_done_q;
   assign o_overflow   = overflow_q;
endmodule

// File: tb/tb_pixel_pack_writer.sv
// tb_pixel_pack_writer: directed table-driven bench for a 4x4 and a 3x3 instance,
// expectations follow PACK_BIG_ENDIAN_EN when it is defined.
module tb_pixel_pack_writer;
   logic        clk = 1'b0, rst = 1'b1, wr = 1'b0, ack = 1'b0, clr = 1'b0;
   logic [7:0]  data = '0;
   logic        req0, req1, fd0, fd1, ovf0, ovf1;
   logic [15:0] addr0, addr1;
   logic [31:0] wd0, wd1;
   logic [3:0]  be0, be1;
   int          tests = 0, fails = 0, fdc0 = 0, fdc1 = 0;
   logic [51:0] q0[$], q1[$];
   logic        hold_v = 1'b0;
   logic [51:0] held;
   logic [7:0]  lfsr;
   typedef struct {
      int          dut;
      int          idx;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      string       name;
   } vec_t;
   vec_t tbl[7];

   always #5 clk = ~clk;

   pixel_pack_writer u0 (
      .clk(clk), .rst(rst), .i_wr(wr), .i_data(data), .o_mem_req(req0), .o_mem_addr(addr0),
      .o_mem_wdata(wd0), .o_mem_be(be0), .i_mem_ack(ack), .o_frame_done(fd0),
      .o_overflow(ovf0), .i_clr(clr));
   pixel_pack_writer #(.WIDTH_IMAG(3), .HEIGHT_IMAG(3)) u1 (
      .clk(clk), .rst(rst), .i_wr(wr), .i_data(data), .o_mem_req(req1), .o_mem_addr(addr1),
      .o_mem_wdata(wd1), .o_mem_be(be1), .i_mem_ack(ack), .o_frame_done(fd1),
      .o_overflow(ovf1), .i_clr(clr));

   function automatic logic [31:0] pk(input logic [31:0] w);
`ifdef PACK_BIG_ENDIAN_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction
   function automatic logic [3:0] pb(input logic [3:0] b);
`ifdef PACK_BIG_ENDIAN_EN
      return {b[0], b[1], b[2], b[3]};
`else
      return b;
`endif
   endfunction
   function automatic logic [31:0] mkw(input logic [7:0] p);
      return pk({p + 8'd3, p + 8'd2, p + 8'd1, p});
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cmp_vec(input int i, input logic [51:0] got);
      check({tbl[i].name, "_addr"}, 64'(got[51:36]), 64'(tbl[i].addr));
      check({tbl[i].name, "_wdata"}, 64'(got[35:4]), 64'(tbl[i].wdata));
      check({tbl[i].name, "_be"}, 64'(got[3:0]), 64'(tbl[i].be));
   endtask

   // Handshakes complete at the posedge following the negedge where req && ack is seen.
   always @(negedge clk) begin
      if (!rst) begin
         if (req0 && ack) q0.push_back({addr0, wd0, be0});
         if (req1 && ack) q1.push_back({addr1, wd1, be1});
         if (fd0) fdc0++;
         if (fd1) fdc1++;
         if (hold_v) begin
            check("hold_req", 64'(req0), 64'd1);
            check("hold_word", 64'({addr0, wd0, be0}), 64'(held));
         end
         hold_v = req0 && !ack;
         held   = {addr0, wd0, be0};
      end else hold_v = 1'b0;
   end

   task automatic do_reset();
      rst = 1'b1; wr = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      q0.delete(); q1.delete();
      fdc0 = 0; fdc1 = 0;
   endtask

   task automatic send(input logic [7:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         wr = 1'b1; data = p + 8'(i);
         @(posedge clk); #1;
      end
      wr = 1'b0;
   endtask

   task automatic wait_q(input int dut, input int n, input int budget);
      int c = 0;
      while (((dut == 0) ? q0.size() : q1.size()) < n && c < budget) begin
         @(posedge clk); #1; c++;
      end
      check("wait_writes", 64'(((dut == 0) ? q0.size() : q1.size()) >= n), 64'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 0, 16'd0, pk(32'h04030201), 4'hF, "f44_w0"};
      tbl[1] = '{0, 1, 16'd1, pk(32'h08070605), 4'hF, "f44_w1"};
      tbl[2] = '{0, 2, 16'd2, pk(32'h0C0B0A09), 4'hF, "f44_w2"};
      tbl[3] = '{0, 3, 16'd3, pk(32'h100F0E0D), 4'hF, "f44_w3"};
      tbl[4] = '{1, 0, 16'd0, pk(32'hA4A3A2A1), 4'hF, "f33_w0"};
      tbl[5] = '{1, 1, 16'd1, pk(32'hA8A7A6A5), 4'hF, "f33_w1"};
      tbl[6] = '{1, 2, 16'd2, pk(32'h000000A9), pb(4'h1), "f33_w2"};

      // reset values
      @(posedge clk); #1;
      check("rst_req", 64'(req0), 64'd0);
      check("rst_addr", 64'(addr0), 64'd0);
      check("rst_wdata", 64'(wd0), 64'd0);
      check("rst_be", 64'(be0), 64'd0);
      check("rst_fd", 64'(fd0), 64'd0);
      check("rst_ovf", 64'(ovf0), 64'd0);
      do_reset();

      // full 4x4 frame with ack tied high, then the next frame restarts at BASE_ADDR
      ack = 1'b1;
      send(8'h01, 16);
      wait_q(0, 4, 50);
      idle(4);
      for (int i = 0; i < 4; i++) cmp_vec(i, q0[tbl[i].idx]);
      check("f44_done_cnt", 64'(fdc0), 64'd1);
      send(8'h11, 16);
      wait_q(0, 8, 50);
      check("f44_next_addr", 64'(q0[4][51:36]), 64'd0);
      check("f44_next_wdata", 64'(q0[4][35:4]), 64'(mkw(8'h11)));

      // 3x3 frame ends in a partial word
      do_reset();
      send(8'hA1, 9);
      wait_q(1, 3, 50);
      idle(4);
      for (int i = 4; i < 7; i++) cmp_vec(i, q1[tbl[i].idx]);
      check("f33_cnt", 64'(q1.size()), 64'd3);
      check("f33_done_cnt", 64'(fdc1), 64'd1);

      // latency: push at edge N, req visible after edge N+1
      do_reset();
      ack = 1'b0;
      send(8'h01, 4);
      @(negedge clk);
      check("lat_req_n", 64'(req0), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_req_n1", 64'(req0), 64'd1);
      check("lat_wdata", 64'(wd0), 64'(mkw(8'h01)));
      check("lat_be", 64'(be0), 64'hF);
      @(posedge clk); #1;

      // reset during an outstanding request and a partial word
      send(8'h05, 2);
      idle(2);
      rst = 1'b1; #1;
      check("mid_rst_req", 64'(req0), 64'd0);
      check("mid_rst_addr", 64'(addr0), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      q0.delete(); fdc0 = 0;
      ack = 1'b1;
      send(8'h31, 16);
      wait_q(0, 4, 50);
      check("mid_rst_addr0", 64'(q0[0][51:36]), 64'd0);
      check("mid_rst_word0", 64'(q0[0][35:4]), 64'(mkw(8'h31)));
      check("mid_rst_addr3", 64'(q0[3][51:36]), 64'd3);

      // overflow: ack held low for 40 cycles across two frames
      do_reset();
      ack = 1'b0;
      send(8'h01, 32);
      idle(8);
      check("ovf_set", 64'(ovf0), 64'd1);
      check("ovf_req", 64'(req0), 64'd1);
      check("ovf_head", 64'(wd0), 64'(mkw(8'h01)));
      ack = 1'b1;
      wait_q(0, 4, 50);
      idle(6);
      check("ovf_wr_cnt", 64'(q0.size()), 64'd4);
      for (int i = 0; i < 4; i++) cmp_vec(i, q0[i]);
      check("ovf_done_cnt", 64'(fdc0), 64'd1);
      check("ovf_sticky", 64'(ovf0), 64'd1);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      check("ovf_clr", 64'(ovf0), 64'd0);
      @(posedge clk); #1;

      // pseudo-random ack stalls over two frames
      do_reset();
      lfsr = 8'hA5;
      fork
         send(8'h01, 32);
         repeat (48) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            ack  = lfsr[0] | lfsr[2];
            @(posedge clk); #1;
         end
      join
      ack = 1'b1;
      wait_q(0, 8, 100);
      idle(4);
      check("rnd_wr_cnt", 64'(q0.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         check("rnd_addr", 64'(q0[i][51:36]), 64'(i % 4));
         check("rnd_wdata", 64'(q0[i][35:4]), 64'(mkw(8'(1 + 4 * i))));
      end
      check("rnd_done_cnt", 64'(fdc0), 64'd2);
      check("rnd_no_ovf", 64'(ovf0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pixel_pack_writer.md
Name: pixel_pack_writer

Overview:
- Downstream neighbour of the sharpening filter stage. Consumes its `wr_file`/`data_out` pixel stream, which is valid-only with no backpressure.
- Packs consecutive pixels into bus-wide words and buffers them in a small FIFO.
- Writes the words into a word-addressed frame buffer over a req/ack memory write port.
- Signals frame completion and any lost data.

Parameters:
- DATA_WIDTH, 8, pixel width in bits
- WIDTH_IMAG, 4, image width in pixels
- HEIGHT_IMAG, 4, image height in pixels
- BUS_WIDTH, 32, memory data width; must be a multiple of DATA_WIDTH
- ADDR_WIDTH, 16, memory word-address width
- BASE_ADDR, 0, word address of the first word of each frame
- FIFO_DEPTH, 4, word FIFO entries; power of 2, minimum 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- i_wr  in  1  pixel valid (filter `wr_file`)
- i_data  in  DATA_WIDTH  pixel (filter `data_out`)
- o_mem_req  out  1  write request
- o_mem_addr  out  ADDR_WIDTH  word address
- o_mem_wdata  out  BUS_WIDTH  packed word
- o_mem_be  out  BUS_WIDTH/DATA_WIDTH  lane enables
- i_mem_ack  in  1  write accepted
- o_frame_done  out  1  one-cycle pulse when the last word of a frame is acked
- o_overflow  out  1  sticky: a word was dropped
- i_clr  in  1  synchronous clear of o_overflow

Behaviour:
- Reset values: all outputs 0; o_mem_addr = BASE_ADDR. FIFO is emptied, lane counter and pixel counter are 0, FSM is in IDLE.
- Packing:
  - LANES = BUS_WIDTH/DATA_WIDTH.
  - On each i_wr, i_data is written into lane `lane_cnt` (lane 0 = bits [DATA_WIDTH-1:0]) and its be bit is set.
  - lane_cnt and pix_cnt then increment.
- Push: when lane_cnt == LANES-1 or pix_cnt == WIDTH_IMAG*HEIGHT_IMAG-1, {word, be, last} is pushed that same edge.
  - last = 1 iff this is the final pixel of the frame.
  - Pack register, be and lane_cnt clear after the push; pix_cnt wraps to 0 on the final pixel.
  - A partial final word carries only the filled lanes in be; unfilled lanes of wdata are 0.
- FIFO full:
  - A push while full with no pop that cycle drops the word and sets o_overflow. The sticky flag holds until i_clr or rst.
  - Push and pop in the same cycle while full are both honoured; no overflow.
  - A dropped word still advances pix_cnt. When the dropped word is the last of a frame, o_frame_done is suppressed for that frame.
- Write FSM, two states:
  - IDLE: o_mem_req = 0. Go to REQ when the FIFO is non-empty.
  - REQ: o_mem_req = 1. o_mem_wdata, o_mem_be and o_mem_addr are registered from the FIFO head and held stable until i_mem_ack.
  - On ack: pop; o_mem_addr advances by 1, or returns to BASE_ADDR if the entry had last = 1.
  - If the entry had last = 1, o_frame_done pulses on the next cycle.
  - After ack, go to IDLE if the FIFO becomes empty; otherwise stay in REQ and present the next entry the next cycle (back-to-back, one word per cycle at best).
- i_mem_ack while o_mem_req = 0 is ignored.
- Latency: a word pushed into an empty FIFO at edge N gives o_mem_req = 1 after edge N+1.
- A mid-operation rst drops the request immediately and discards the FIFO and the partial word.
- i_clr affects only o_overflow.

Optional Feature:
- Macro: PACK_BIG_ENDIAN_EN.
- Defined: the first pixel of a word goes to the most-significant lane, and be bit order mirrors the lanes.
- Undefined: little-endian packing as described in Behaviour.

Decomposition:
- Shared package pixel_pack_pkg holds:
  - derived constants LANES, LANE_CNT_W, FRAME_PIX, PIX_CNT_W, WORDS_PER_FRAME
  - the FIFO entry typedef {last, be, wdata}
  - the FSM state enum IDLE/REQ
- One sub-module: pp_sync_fifo, a generic single-clock FIFO with full/empty flags and simultaneous push/pop.

Test Plan (default parameters, 4x4 frame):
- Pixels 0x01..0x10 on consecutive cycles, i_mem_ack tied 1 → four writes:
  - addr 0 wdata 0x04030201
  - addr 1 wdata 0x08070605
  - addr 2 wdata 0x0C0B0A09
  - addr 3 wdata 0x100F0E0D
  - be = 0xF on every write; o_frame_done pulses once after the 4th ack; the next frame starts at addr 0.
- WIDTH_IMAG=3, HEIGHT_IMAG=3, 9 pixels 0xA1..0xA9 → three words, the last being wdata 0x000000A9 with be 0x1.
- i_mem_ack held 0 for 40 cycles during a frame → FIFO fills, o_overflow = 1, o_frame_done suppressed for that frame; i_clr clears o_overflow.
- Random i_mem_ack stalls → o_mem_addr, o_mem_wdata and o_mem_be stay stable while o_mem_req = 1 and ack = 0; no word lost or duplicated.
- rst asserted while o_mem_req = 1 → o_mem_req = 0 immediately; the next frame starts at BASE_ADDR with lane 0.
- PACK_BIG_ENDIAN_EN defined with pixels 0x01..0x04 → wdata 0x01020304.
